// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/fullAdder.sv
// Dataflow one-bit full adder cell.
module fullAdder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic cout,
   output logic s
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands plus carry-in, LSB first, one bit per clock
// through a single full-adder cell.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout
);

   localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] s_sh_q, s_sh_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             cout_q, cout_d;

   logic             fa_s, fa_cout;
   logic [WIDTH-1:0] s_shift;

   fullAdder u_fa (
      .a    (a_sh_q[0]),
      .b    (b_sh_q[0]),
      .cin  (carry_q),
      .cout (fa_cout),
      .s    (fa_s)
   );

   // New sum bit enters at the MSB; the truncating cast also covers WIDTH=1, where the
   // result is just fa_s.
   assign s_shift = WIDTH'({fa_s, s_sh_q} >> 1);

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      s_sh_d  = s_sh_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      s_d     = s_q;
      cout_d  = cout_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b;
               carry_d = cin;
               cnt_d   = '0;
               s_sh_d  = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            carry_d = fa_cout;
            s_sh_d  = s_shift;
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            cnt_d   = cnt_q + CntW'(1);
            if (cnt_q == CntLast) begin
               s_d     = s_shift;
               cout_d  = fa_cout;
               // Park the counter so it never exceeds WIDTH-1 for non-power-of-two widths.
               cnt_d   = '0;
               state_d = StDone;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         s_sh_q  <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         s_q     <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         s_sh_q  <= s_sh_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
      end
   end

   assign busy = (state_q == StRun);
   assign done = (state_q == StDone);
   assign s    = s_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;

   logic       clk;
   logic       rst;
   logic       start8, cin8, busy8, done8, cout8;
   logic [7:0] a8, b8, s8;
   logic       start1, a1, b1, cin1, busy1, done1, s1, cout1;

   int checks = 0;
   int errs   = 0;

   serial_adder #(.WIDTH(8)) u_dut8 (
      .clk   (clk),
      .rst   (rst),
      .start (start8),
      .a     (a8),
      .b     (b8),
      .cin   (cin8),
      .busy  (busy8),
      .done  (done8),
      .s     (s8),
      .cout  (cout8)
   );

   serial_adder #(.WIDTH(1)) u_dut1 (
      .clk   (clk),
      .rst   (rst),
      .start (start1),
      .a     (a1),
      .b     (b1),
      .cin   (cin1),
      .busy  (busy1),
      .done  (done1),
      .s     (s1),
      .cout  (cout1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One WIDTH=8 addition; optional stray start pulses during RUN (at cycle pulse_run) and DONE.
   task automatic run8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                       input logic tc, input logic [7:0] es, input logic ec,
                       input int pulse_run, input bit pulse_done);
      int busy_cnt;
      int done_early;
      busy_cnt   = 0;
      done_early = 0;
      @(negedge clk);
      start8 = 1'b1;
      a8     = ta;
      b8     = tb;
      cin8   = tc;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         a8   = ~ta;
         b8   = ~tb;
         cin8 = ~tc;
         if (k == pulse_run) begin
            start8 = 1'b1;
            a8     = 8'hAA;
            b8     = 8'h55;
         end else begin
            start8 = 1'b0;
         end
         if (busy8) busy_cnt++;
         if (done8) done_early++;
      end
      check_eq({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
      check_eq({tag, "_no_early_done"}, 32'(done_early), 32'd0);
      @(negedge clk);
      check_eq({tag, "_done"}, 32'(done8), 32'd1);
      check_eq({tag, "_busy_in_done"}, 32'(busy8), 32'd0);
      check_eq({tag, "_s"}, 32'(s8), 32'(es));
      check_eq({tag, "_cout"}, 32'(cout8), 32'(ec));
      start8 = pulse_done;
      a8     = 8'hAA;
      b8     = 8'h55;
      @(negedge clk);
      start8 = 1'b0;
      check_eq({tag, "_done_cleared"}, 32'(done8), 32'd0);
      check_eq({tag, "_idle_after"}, 32'(busy8), 32'd0);
   endtask

   task automatic run1(input logic ta, input logic tb, input logic tc);
      logic es, ec;
      es = ta ^ tb ^ tc;
      ec = (ta & tb) | (ta & tc) | (tb & tc);
      @(negedge clk);
      start1 = 1'b1;
      a1     = ta;
      b1     = tb;
      cin1   = tc;
      @(negedge clk);
      start1 = 1'b0;
      a1     = ~ta;
      b1     = ~tb;
      cin1   = ~tc;
      check_eq($sformatf("w1_%0d%0d%0d_busy", ta, tb, tc), 32'({busy1, done1}), 32'b10);
      @(negedge clk);
      check_eq($sformatf("w1_%0d%0d%0d_done", ta, tb, tc), 32'({busy1, done1}), 32'b01);
      check_eq($sformatf("w1_%0d%0d%0d_sum", ta, tb, tc), 32'({cout1, s1}), 32'({ec, es}));
      @(negedge clk);
      check_eq($sformatf("w1_%0d%0d%0d_idle", ta, tb, tc), 32'({busy1, done1}), 32'b00);
   endtask

   initial begin
      int seen;
      rst    = 1'b1;
      start8 = 1'b0;
      a8     = 8'h00;
      b8     = 8'h00;
      cin8   = 1'b0;
      start1 = 1'b0;
      a1     = 1'b0;
      b1     = 1'b0;
      cin1   = 1'b0;
      #1;
      check_eq("reset_outputs8", 32'({busy8, done8, cout8, s8}), 32'd0);
      check_eq("reset_outputs1", 32'({busy1, done1, cout1, s1}), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      run8("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 0, 1'b0);
      run8("carry_chain", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, 1'b0);
      run8("cin_3c42", 8'h3C, 8'h42, 1'b1, 8'h7F, 1'b0, 0, 1'b0);
      run8("cin_ffff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0, 1'b0);
      run8("ignored_start", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 3, 1'b1);
      run8("after_ignore", 8'h81, 8'h7F, 1'b0, 8'h00, 1'b1, 0, 1'b0);
      run8("mixed", 8'h5A, 8'h27, 1'b1, 8'h82, 1'b0, 0, 1'b0);

      // Abort a run mid-way with an asynchronous reset.
      @(negedge clk);
      start8 = 1'b1;
      a8     = 8'hFF;
      b8     = 8'h01;
      cin8   = 1'b0;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("pre_abort_busy", 32'(busy8), 32'd1);
      #2 rst = 1'b1;
      #1;
      check_eq("abort_busy", 32'(busy8), 32'd0);
      check_eq("abort_done", 32'(done8), 32'd0);
      check_eq("abort_s", 32'(s8), 32'd0);
      check_eq("abort_cout", 32'(cout8), 32'd0);
      @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (done8 || busy8) seen++;
      end
      check_eq("abort_no_done", 32'(seen), 32'd0);
      check_eq("abort_s_held", 32'({cout8, s8}), 32'd0);
      run8("post_abort", 8'hC3, 8'h5D, 1'b0, 8'h20, 1'b1, 0, 1'b0);

      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = 3'(i);
         run1(v[2], v[1], v[0]);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
